pushbutton_decryptor: RTL and testbench
=======================================

Name: pushbutton_decryptor

Overview:
- Receiving end of the button-driven RSA chain: buffers 8-bit ciphertext bytes from the encryption side in a 16-entry FIFO.
- On each debounced press of a second button, pops one byte and decrypts it: m = c^D mod N, right-to-left square-and-multiply.
- Presents the plaintext with a one-cycle valid pulse and a running message index.
- Fully self-contained: no ROM or IP instances.

Parameters:
- Width, 8, data width of ciphertext and plaintext; must hold N-1.
- N, 55, RSA modulus.
- D, 7, private exponent (pairs with e=23 for N=55).
- DW, 8, exponent bits processed; one EXP cycle per bit.
- AW, 4, FIFO address width; depth = 2^AW = 16.

Ports:
- btn_clk, input, 1, sole clock; all logic is on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- btn, input, 1, raw push button; asynchronous to btn_clk.
- ct_wr_en, input, 1, write strobe; one ciphertext byte per cycle.
- ct_wr_data, input, Width, ciphertext byte.
- plaintext, output, Width, last decrypted byte; held until the next result.
- pt_valid, output, 1, one-cycle pulse when plaintext updates.
- pt_addr, output, AW, index of the next message to decrypt; increments per result.
- busy, output, 1, high in every state except IDLE.
- ct_empty, output, 1, FIFO empty.
- ct_full, output, 1, FIFO full.
- ct_count, output, AW+1, FIFO occupancy, 0..16.
- overflow, output, 1, sticky; set when a write is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs 0 except ct_empty=1; FIFO pointers and count cleared; FSM in IDLE. Assertion mid-operation aborts the decryption with no pt_valid.
- Button input: btn passes through a 2-flop synchronizer (s1, s2) plus a previous-value flop. press_evt = s2 & ~prev. Exactly one event per press, however long btn is held.
- FIFO writes: ct_wr_en with the FIFO not full writes the byte and increments the write pointer. With the FIFO full, the write is dropped and overflow is set.
- FIFO pop: happens only on the IDLE->LOAD transition.
- Simultaneous write and pop: both take effect and ct_count is unchanged. A pop with the FIFO full frees a slot, so a write in that same cycle is accepted.
- Pointers wrap modulo 16. ct_full = (ct_count==16); ct_empty = (ct_count==0).
- FSM states: IDLE, LOAD, EXP, DONE.
- IDLE: leaves on press_evt & ~ct_empty and goes to LOAD.
  - press_evt with the FIFO empty is ignored.
  - press_evt while busy is ignored and not queued.
- LOAD (1 cycle):
  - base <= c % N, where c is the popped byte.
  - result <= 1, exp <= D, bitcnt <= 0.
  - Next state EXP.
- EXP (DW cycles), each cycle:
  - if exp[0], result <= (result*base) % N;
  - base <= (base*base) % N;
  - exp <= exp >> 1; bitcnt++.
  - After the DW-th cycle, go to DONE.
- Arithmetic: products are 2*Width bits unsigned; reduction by the constant N is single-cycle combinational.
- DONE (1 cycle): plaintext <= result; pt_valid <= 1 for the following cycle only; pt_addr <= pt_addr+1 (wraps 15->0); next state IDLE.
- Latency, with btn first sampled high at edge E0:
  - LOAD is entered at E2.
  - EXP covers E3..E(2+DW).
  - DONE is entered at E(3+DW).
  - pt_valid is high after E(4+DW), i.e. after E12 for DW=8.
- Back-to-back: a new press is accepted in any IDLE cycle, including the cycle in which pt_valid is high.

Test Plan:
- Reset, write 2 bytes 8 then 27, press twice with btn released between presses:
  - plaintext 2 with pt_valid 12 edges after the first press;
  - then plaintext 3;
  - pt_addr 0->1->2; ct_count 2->1->0; ct_empty=1.
- Edge values: ciphertext 0 -> plaintext 0; ciphertext 1 -> plaintext 1; ciphertext 55 (reduced to 0) -> plaintext 0.
- Hold btn high for 50 cycles with 3 bytes queued -> exactly one pt_valid pulse, ct_count 3->2.
- Write 17 bytes -> ct_full=1 after the 16th; the 17th is dropped and overflow=1, stays set.
- Wrap and ordering: after 17 more writes and 16 presses, pt_addr wraps to 0 and output order matches write order.
- Press with the FIFO empty -> no state change, busy=0, no pt_valid.
- Assert rst at the 4th EXP cycle -> no pt_valid, all outputs 0, ct_empty=1; a later write plus press decrypts correctly.
- Write in the same cycle as a pop with the FIFO full -> both take effect, ct_count stays 16, overflow stays 0.

Source files
------------

// File: rtl/pushbutton_decryptor_if.sv
// Ciphertext write port and plaintext/status outputs of the push-button decryptor.
interface pushbutton_decryptor_if #(
  parameter int unsigned Width = 8,
  parameter int unsigned AW    = 4
);
  logic             ct_wr_en;
  logic [Width-1:0] ct_wr_data;
  logic [Width-1:0] plaintext;
  logic             pt_valid;
  logic [AW-1:0]    pt_addr;
  logic             busy;
  logic             ct_empty;
  logic             ct_full;
  logic [AW:0]      ct_count;
  logic             overflow;

  modport master (
    output ct_wr_en, ct_wr_data,
    input  plaintext, pt_valid, pt_addr, busy, ct_empty, ct_full, ct_count, overflow
  );

  modport slave (
    input  ct_wr_en, ct_wr_data,
    output plaintext, pt_valid, pt_addr, busy, ct_empty, ct_full, ct_count, overflow
  );
endinterface

// File: rtl/pushbutton_decryptor.sv
// Push-button RSA decryptor: ciphertext FIFO, debounced press detect, and a
// right-to-left square-and-multiply engine computing m = c^D mod N.
module pushbutton_decryptor #(
  parameter int unsigned Width = 8,
  parameter int unsigned N     = 55,
  parameter int unsigned D     = 7,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 4
) (
  input  logic                   btn_clk,
  input  logic                   rst,
  input  logic                   btn,
  pushbutton_decryptor_if.slave  bus
);

  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned CW    = $clog2(DW) + 1;
  localparam logic [Width-1:0]   NMOD  = Width'(N);
  localparam logic [2*Width-1:0] NWIDE = (2*Width)'(N);
  localparam logic [DW-1:0]      DEXP  = DW'(D);
  localparam logic [CW-1:0]      LAST  = CW'(DW - 1);
  localparam logic [AW:0]        FULLC = (AW+1)'(Depth);

  typedef enum logic [1:0] {IDLE, LOAD, EXP, DONE} state_t;

  state_t state, next_state;

  logic s1, s2, prev;
  logic press_evt;

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             overflow;
  logic             empty, full;
  logic             pop, wr_ok;

  logic [Width-1:0] c_reg, base, result, plaintext;
  logic [DW-1:0]    exp_reg;
  logic [CW-1:0]    bitcnt;
  logic             pt_valid;
  logic [AW-1:0]    pt_addr;

  logic [2*Width-1:0] prod_rm, prod_sq, mod_rm, mod_sq;

  assign press_evt = s2 & ~prev;
  assign empty     = (count == '0);
  assign full      = (count == FULLC);
  // A pop in the same cycle frees a slot, so a write to a full FIFO is kept.
  assign wr_ok     = bus.ct_wr_en & (~full | pop);

  assign prod_rm = {{Width{1'b0}}, result} * {{Width{1'b0}}, base};
  assign prod_sq = {{Width{1'b0}}, base} * {{Width{1'b0}}, base};
  assign mod_rm  = prod_rm % NWIDE;
  assign mod_sq  = prod_sq % NWIDE;

  // Two-flop synchronizer plus previous-value flop for rising-edge detect.
  always_ff @(posedge btn_clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge btn_clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.ct_wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge btn_clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.ct_wr_en && !wr_ok) overflow <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge btn_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next-state; the pop is issued only on the IDLE->LOAD transition.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (press_evt && !empty) begin
        next_state = LOAD;
        pop        = 1'b1;
      end
      LOAD:    next_state = EXP;
      EXP:     if (bitcnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Exponentiation datapath and result presentation.
  always_ff @(posedge btn_clk or posedge rst) begin
    if (rst) begin
      c_reg     <= '0;
      base      <= '0;
      result    <= '0;
      exp_reg   <= '0;
      bitcnt    <= '0;
      plaintext <= '0;
      pt_valid  <= 1'b0;
      pt_addr   <= '0;
    end else begin
      pt_valid <= 1'b0;
      if (pop) c_reg <= mem[rd_ptr];
      case (state)
        LOAD: begin
          base    <= c_reg % NMOD;
          result  <= {{(Width-1){1'b0}}, 1'b1};
          exp_reg <= DEXP;
          bitcnt  <= '0;
        end
        EXP: begin
          if (exp_reg[0]) result <= mod_rm[Width-1:0];
          base    <= mod_sq[Width-1:0];
          exp_reg <= exp_reg >> 1;
          bitcnt  <= bitcnt + 1'b1;
        end
        DONE: begin
          plaintext <= result;
          pt_valid  <= 1'b1;
          pt_addr   <= pt_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.plaintext = plaintext;
  assign bus.pt_valid  = pt_valid;
  assign bus.pt_addr   = pt_addr;
  assign bus.busy      = (state != IDLE);
  assign bus.ct_empty  = empty;
  assign bus.ct_full   = full;
  assign bus.ct_count  = count;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_pushbutton_decryptor.sv
// Directed bench for pushbutton_decryptor (N=55, D=7, DW=8, 16-deep FIFO).
module tb_pushbutton_decryptor;

  logic btn_clk = 1'b0;
  logic rst;
  logic btn;

  pushbutton_decryptor_if #(.Width(8), .AW(4)) bus ();

  pushbutton_decryptor #(.Width(8), .N(55), .D(7), .DW(8), .AW(4)) dut (
    .btn_clk (btn_clk),
    .rst     (rst),
    .btn     (btn),
    .bus     (bus)
  );

  always #5 btn_clk = ~btn_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // c^7 mod 55 for ciphertexts 2..17
  logic [7:0] exp_tab [16] = '{18, 42, 49, 25, 41, 28, 2, 4, 10, 11, 23, 7, 9, 5, 36, 8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge btn_clk);
    bus.ct_wr_en   = 1'b1;
    bus.ct_wr_data = d;
    @(negedge btn_clk);
    bus.ct_wr_en   = 1'b0;
  endtask

  // Press, wait for the result, check latency/value/index, release and settle.
  task automatic press_check(input logic [7:0] exp_pt, input int exp_addr, input string tag);
    int lat;
    bit got;
    lat = 99;
    got = 1'b0;
    @(negedge btn_clk);
    btn = 1'b1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge btn_clk);
      #1;
      if (bus.pt_valid) begin
        got = 1'b1;
        lat = i - 1;
      end
    end
    chk({tag, "_latency"}, lat, 12);
    chk({tag, "_pt"}, bus.plaintext, exp_pt);
    chk({tag, "_addr"}, bus.pt_addr, exp_addr);
    @(posedge btn_clk);
    #1;
    chk({tag, "_pulse1"}, bus.pt_valid, 0);
    btn = 1'b0;
    repeat (4) @(negedge btn_clk);
  endtask

  initial begin
    int pulses;
    bit seen_busy, seen_pv;
    bit got;

    rst = 1'b1;
    btn = 1'b0;
    bus.ct_wr_en   = 1'b0;
    bus.ct_wr_data = '0;
    repeat (3) @(negedge btn_clk);
    chk("rst_pt", bus.plaintext, 0);
    chk("rst_valid", bus.pt_valid, 0);
    chk("rst_addr", bus.pt_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_empty", bus.ct_empty, 1);
    chk("rst_full", bus.ct_full, 0);
    chk("rst_count", bus.ct_count, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst = 1'b0;
    @(negedge btn_clk);

    // Basic two-message flow
    wr(8'd8);
    wr(8'd27);
    chk("basic_count2", bus.ct_count, 2);
    press_check(8'd2, 1, "basic_a");
    chk("basic_count1", bus.ct_count, 1);
    press_check(8'd3, 2, "basic_b");
    chk("basic_count0", bus.ct_count, 0);
    chk("basic_empty", bus.ct_empty, 1);

    // Edge values: 0, 1 and 55 (reduces to 0)
    wr(8'd0);
    wr(8'd1);
    wr(8'd55);
    press_check(8'd0, 3, "edge_0");
    press_check(8'd1, 4, "edge_1");
    press_check(8'd0, 5, "edge_55");

    // Long hold produces exactly one decryption
    wr(8'd2);
    wr(8'd3);
    wr(8'd4);
    chk("hold_count3", bus.ct_count, 3);
    @(negedge btn_clk);
    btn = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(posedge btn_clk);
      #1;
      if (bus.pt_valid) pulses++;
    end
    btn = 1'b0;
    chk("hold_pulses", pulses, 1);
    chk("hold_count2", bus.ct_count, 2);
    chk("hold_pt", bus.plaintext, 18);
    chk("hold_addr", bus.pt_addr, 6);
    repeat (4) @(negedge btn_clk);
    press_check(8'd42, 7, "hold_drain_a");
    press_check(8'd49, 8, "hold_drain_b");

    // Press with empty FIFO is ignored
    chk("empty_pre", bus.ct_empty, 1);
    @(negedge btn_clk);
    btn = 1'b1;
    seen_busy = 1'b0;
    seen_pv   = 1'b0;
    repeat (10) begin
      @(posedge btn_clk);
      #1;
      seen_busy |= bus.busy;
      seen_pv   |= bus.pt_valid;
    end
    btn = 1'b0;
    chk("empty_busy", seen_busy, 0);
    chk("empty_pv", seen_pv, 0);
    chk("empty_addr", bus.pt_addr, 8);
    repeat (4) @(negedge btn_clk);

    // Fill, overflow, then drain in order across the index wrap
    for (int i = 0; i < 16; i++) wr(8'(2 + i));
    chk("fill_full", bus.ct_full, 1);
    chk("fill_count", bus.ct_count, 16);
    chk("fill_ovf0", bus.overflow, 0);
    wr(8'd50);
    chk("fill_ovf1", bus.overflow, 1);
    chk("fill_count_after", bus.ct_count, 16);
    for (int i = 0; i < 16; i++)
      press_check(exp_tab[i], (9 + i) % 16, $sformatf("drain%0d", i));
    chk("drain_empty", bus.ct_empty, 1);
    chk("drain_ovf_sticky", bus.overflow, 1);
    chk("drain_addr", bus.pt_addr, 8);

    // Reset during the 4th EXP cycle aborts the decryption
    wr(8'd13);
    @(negedge btn_clk);
    btn = 1'b1;
    @(posedge btn_clk);
    repeat (6) @(posedge btn_clk);
    #1;
    chk("abort_busy_pre", bus.busy, 1);
    rst = 1'b1;
    btn = 1'b0;
    #2;
    chk("abort_pv", bus.pt_valid, 0);
    chk("abort_pt", bus.plaintext, 0);
    chk("abort_addr", bus.pt_addr, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_empty", bus.ct_empty, 1);
    chk("abort_count", bus.ct_count, 0);
    chk("abort_ovf", bus.overflow, 0);
    @(negedge btn_clk);
    rst = 1'b0;
    seen_pv = 1'b0;
    repeat (20) begin
      @(posedge btn_clk);
      #1;
      seen_pv |= bus.pt_valid;
    end
    chk("abort_no_pv", seen_pv, 0);
    chk("abort_idle", bus.busy, 0);
    wr(8'd14);
    press_check(8'd9, 1, "after_abort");

    // Write coinciding with a pop while full
    for (int i = 0; i < 16; i++) wr(8'(2 + i));
    chk("simul_full_pre", bus.ct_full, 1);
    @(negedge btn_clk);
    btn = 1'b1;
    @(posedge btn_clk);
    @(posedge btn_clk);
    #1;
    bus.ct_wr_en   = 1'b1;
    bus.ct_wr_data = 8'd5;
    @(posedge btn_clk);
    #1;
    bus.ct_wr_en = 1'b0;
    chk("simul_busy", bus.busy, 1);
    chk("simul_count", bus.ct_count, 16);
    chk("simul_ovf", bus.overflow, 0);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge btn_clk);
      #1;
      if (bus.pt_valid) got = 1'b1;
    end
    chk("simul_got", got, 1);
    chk("simul_pt", bus.plaintext, 18);
    chk("simul_addr", bus.pt_addr, 2);
    @(negedge btn_clk);
    btn = 1'b0;
    repeat (4) @(negedge btn_clk);
    for (int i = 1; i < 16; i++)
      press_check(exp_tab[i], (2 + i) % 16, $sformatf("simul_drain%0d", i));
    press_check(8'd25, 2, "simul_last");
    chk("simul_end_empty", bus.ct_empty, 1);
    chk("simul_end_ovf", bus.overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
